// File: rtl/cmd_frame_pkg.sv
// Shared types for the command frame decoder: opcode bytes, command and
// error encodings, FSM states and the opcode-byte decode helpers.
package cmd_frame_pkg;

    localparam int OPC_WIDTH = 8;

    // First byte of each frame type.
    localparam logic [OPC_WIDTH-1:0] OPC_WR      = 8'hAA;
    localparam logic [OPC_WIDTH-1:0] OPC_RD      = 8'hBB;
    localparam logic [OPC_WIDTH-1:0] OPC_ALU     = 8'hCC;
    localparam logic [OPC_WIDTH-1:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'b00,
        CMD_RD      = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_OPCODE  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_WDATA = 3'd2,
        ST_GET_OPA   = 3'd3,
        ST_GET_OPB   = 3'd4,
        ST_GET_FUN   = 3'd5,
        ST_HOLD      = 3'd6
    } state_e;

    typedef struct packed {
        logic    known;
        cmd_op_e op;
    } opcode_dec_t;

    // Map an opcode byte to its command; unknown bytes clear the known flag.
    function automatic opcode_dec_t decode_opcode(input logic [OPC_WIDTH-1:0] b);
        opcode_dec_t d;
        d.known = 1'b1;
        d.op    = CMD_WR;
        case (b)
            OPC_WR:      d.op = CMD_WR;
            OPC_RD:      d.op = CMD_RD;
            OPC_ALU:     d.op = CMD_ALU_OP;
            OPC_ALU_NOP: d.op = CMD_ALU_NOP;
            default:     d.known = 1'b0;
        endcase
        return d;
    endfunction

    // State that collects the second byte of a frame of the given type.
    function automatic state_e first_state(input cmd_op_e op);
        case (op)
            CMD_WR, CMD_RD: return ST_GET_ADDR;
            CMD_ALU_OP:     return ST_GET_OPA;
            default:        return ST_GET_FUN;
        endcase
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap counter. Counts while run_i is high, restarts on clear_i,
// and pulses expire_o in the cycle the count sits on TIMEOUT_CYCLES-1
// without a clear.
module frame_gap_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and expiry; a clear (byte strobe) in the expiry cycle wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = cnt_q;
        expire_o = run_i && !clear_i && (cnt_q == LAST);
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: reset is asynchronous so the counter clears even with the clock stopped.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles synchronized UART RX bytes into WR / RD / ALU_OP / ALU_NOP
// command frames, holds each frame on a valid/ready interface and flags
// bad opcodes, inter-byte timeouts and overruns with a one-cycle strobe.
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [DATA_WIDTH-1:0]    i_RX_P_DATA,
    input  logic                     i_RX_D_VLD,
    input  logic                     i_CMD_READY,
    output logic                     o_CMD_VALID,
    output logic [1:0]               o_CMD_OP,
    output logic [ADDR_WIDTH-1:0]    o_CMD_ADDR,
    output logic [DATA_WIDTH-1:0]    o_CMD_WDATA,
    output logic [DATA_WIDTH-1:0]    o_CMD_OPA,
    output logic [DATA_WIDTH-1:0]    o_CMD_OPB,
    output logic [ALU_FUN_WIDTH-1:0] o_CMD_FUN,
    output logic                     o_FRAME_ERR,
    output logic [1:0]               o_ERR_CODE,
    output logic                     o_BUSY
);

    state_e                   state_q,  state_d;
    cmd_op_e                  op_q,     op_d;
    logic [ADDR_WIDTH-1:0]    addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0]    opa_q,    opa_d;
    logic [DATA_WIDTH-1:0]    opb_q,    opb_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q,    fun_d;
    logic                     valid_q,  valid_d;
    logic                     err_q,    err_d;
    err_code_e                code_q,   code_d;
    logic                     busy_q,   busy_d;

    opcode_dec_t opc_dec;
    logic        in_wait;
    logic        take_opcode;
    logic        gap_clear;
    logic        gap_run;
    logic        gap_expire;

    assign opc_dec = decode_opcode(OPC_WIDTH'(i_RX_P_DATA));

    // IDLE and HOLD are not inside a frame, so the gap timer only runs in GET_* states.
    assign in_wait   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign gap_clear = i_RX_D_VLD || in_wait;
    assign gap_run   = !in_wait;

    // A strobe is an opcode byte in IDLE, and also in the handshake cycle of HOLD.
    assign take_opcode = i_RX_D_VLD &&
                         ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_CMD_READY));

    frame_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_i    (i_CLK),
        .rst_i    (i_RST),
        .clear_i  (gap_clear),
        .run_i    (gap_run),
        .expire_o (gap_expire)
    );

    // Next-state, field capture and error/handshake decisions.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        fun_d   = fun_q;
        err_d   = 1'b0;
        code_d  = code_q;

        case (state_q)
            ST_GET_ADDR: begin
                if (i_RX_D_VLD) begin
                    addr_d  = i_RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = (op_q == CMD_WR) ? ST_GET_WDATA : ST_HOLD;
                end
            end
            ST_GET_WDATA: begin
                if (i_RX_D_VLD) begin
                    wdata_d = i_RX_P_DATA;
                    state_d = ST_HOLD;
                end
            end
            ST_GET_OPA: begin
                if (i_RX_D_VLD) begin
                    opa_d   = i_RX_P_DATA;
                    state_d = ST_GET_OPB;
                end
            end
            ST_GET_OPB: begin
                if (i_RX_D_VLD) begin
                    opb_d   = i_RX_P_DATA;
                    state_d = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                if (i_RX_D_VLD) begin
                    fun_d   = i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_CMD_READY) begin
                    state_d = ST_IDLE;
                end else if (i_RX_D_VLD) begin
                    // No room for a new frame: drop the byte, keep the held one.
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: ;
        endcase

        if (take_opcode) begin
            if (opc_dec.known) begin
                op_d    = opc_dec.op;
                state_d = first_state(opc_dec.op);
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                code_d  = ERR_OPCODE;
            end
        end

        // Expiry only fires in GET_* states with no strobe, so it never competes with the above.
        if (gap_expire) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end

        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, field and output registers; everything visible on the ports is a flop.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            op_q    <= CMD_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            fun_q   <= fun_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign o_CMD_VALID = valid_q;
    assign o_CMD_OP    = op_q;
    assign o_CMD_ADDR  = addr_q;
    assign o_CMD_WDATA = wdata_q;
    assign o_CMD_OPA   = opa_q;
    assign o_CMD_OPB   = opb_q;
    assign o_CMD_FUN   = fun_q;
    assign o_FRAME_ERR = err_q;
    assign o_ERR_CODE  = code_q;
    assign o_BUSY      = busy_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with a short gap timeout.
module tb_cmd_frame_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       ready;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_opa;
    logic [7:0] cmd_opb;
    logic [3:0] cmd_fun;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmd_frame_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_RX_P_DATA(rx_data), .i_RX_D_VLD(rx_vld),
        .i_CMD_READY(ready), .o_CMD_VALID(cmd_valid), .o_CMD_OP(cmd_op),
        .o_CMD_ADDR(cmd_addr), .o_CMD_WDATA(cmd_wdata), .o_CMD_OPA(cmd_opa),
        .o_CMD_OPB(cmd_opb), .o_CMD_FUN(cmd_fun), .o_FRAME_ERR(frame_err),
        .o_ERR_CODE(err_code), .o_BUSY(busy)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        tick();
        rx_vld  = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, frame_err, err_code, busy} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, frame_err, err_code, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({cmd_valid, busy, frame_err} !== 3'b000) begin
            failures++; $display("FAIL reset_release_idle: got %b expected 000", {cmd_valid, busy, frame_err});
        end
    endtask

    task automatic test_wr();
        ready = 1'b1;
        send(8'hAA);
        send(8'h05);
        checks++;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL wr_not_early: got %b expected 0", cmd_valid); end
        send(8'h3C);
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, busy} !== {1'b1, 2'b00, 4'h5, 8'h3C, 1'b1}) begin
            failures++;
            $display("FAIL wr_frame: got v=%b op=%h a=%h d=%h b=%b expected v=1 op=0 a=5 d=3c b=1",
                     cmd_valid, cmd_op, cmd_addr, cmd_wdata, busy);
        end
        tick();
        checks++;
        if ({cmd_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL wr_one_cycle: got v=%b b=%b expected 0 0", cmd_valid, busy);
        end
        ready = 1'b0;
    endtask

    task automatic test_alu_op();
        int bad;
        ready = 1'b0;
        send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_fun} !== {1'b1, 2'b10, 8'h12, 8'h34, 4'h1}) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL alu_hold_stable: got %0d unstable cycles expected 0", bad); end
        accept();
        checks++;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL alu_accept: got %b expected 0", cmd_valid); end
        send(8'hDD); send(8'h0A);
        checks++;
        if ({cmd_valid, cmd_op, cmd_fun, cmd_opa, cmd_opb} !== {1'b1, 2'b11, 4'hA, 8'h12, 8'h34}) begin
            failures++;
            $display("FAIL alu_nop_frame: got v=%b op=%h f=%h a=%h b=%h expected v=1 op=3 f=a a=12 b=34",
                     cmd_valid, cmd_op, cmd_fun, cmd_opa, cmd_opb);
        end
        accept();
    endtask

    task automatic test_bad_opcode();
        send(8'h55);
        checks++;
        if ({frame_err, err_code, busy, cmd_valid} !== {1'b1, 2'b01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bad_opcode: got e=%b c=%h b=%b v=%b expected 1 1 0 0", frame_err, err_code, busy, cmd_valid);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL bad_opcode_pulse: got %b expected 0", frame_err); end
        send(8'hBB); send(8'h0F);
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, frame_err, err_code} !== {1'b1, 2'b01, 4'hF, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL rd_after_bad: got v=%b op=%h a=%h e=%b c=%h expected 1 1 f 0 1",
                     cmd_valid, cmd_op, cmd_addr, frame_err, err_code);
        end
        accept();
    endtask

    task automatic test_timeout();
        int k;
        int early;
        // Silence after AA,03: expiry after TO edges.
        send(8'hAA); send(8'h03);
        k = 0;
        for (int i = 1; i <= 3 * TO && k == 0; i++) begin
            tick();
            if (frame_err === 1'b1) k = i;
        end
        checks++;
        if (k != TO) begin failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TO); end
        checks++;
        if ({err_code, cmd_valid, busy} !== {2'b10, 1'b0, 1'b0}) begin
            failures++; $display("FAIL timeout_state: got c=%h v=%b b=%b expected 2 0 0", err_code, cmd_valid, busy);
        end
        tick();
        // Last byte strobed in the expiry cycle: frame completes.
        send(8'hAA); send(8'h03);
        early = 0;
        repeat (TO - 1) begin
            if (frame_err === 1'b1) early++;
            tick();
        end
        send(8'h3C);
        checks++;
        if (early != 0 || {frame_err, cmd_valid, cmd_op, cmd_addr, cmd_wdata} !== {1'b0, 1'b1, 2'b00, 4'h3, 8'h3C}) begin
            failures++;
            $display("FAIL timeout_boundary: got early=%0d e=%b v=%b op=%h a=%h d=%h expected 0 0 1 0 3 3c",
                     early, frame_err, cmd_valid, cmd_op, cmd_addr, cmd_wdata);
        end
        accept();
    endtask

    task automatic test_overrun();
        send(8'hBB); send(8'h07);
        send(8'h77);
        checks++;
        if ({frame_err, err_code, cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'b11, 1'b1, 2'b01, 4'h7}) begin
            failures++;
            $display("FAIL overrun: got e=%b c=%h v=%b op=%h a=%h expected 1 3 1 1 7",
                     frame_err, err_code, cmd_valid, cmd_op, cmd_addr);
        end
        tick();
        checks++;
        if ({frame_err, cmd_valid, cmd_addr} !== {1'b0, 1'b1, 4'h7}) begin
            failures++; $display("FAIL overrun_hold: got e=%b v=%b a=%h expected 0 1 7", frame_err, cmd_valid, cmd_addr);
        end
        // Opcode strobe in the handshake cycle.
        ready = 1'b1; rx_data = 8'hBB; rx_vld = 1'b1;
        tick();
        ready = 1'b0; rx_vld = 1'b0;
        checks++;
        if ({cmd_valid, busy, frame_err} !== 3'b010) begin
            failures++; $display("FAIL handshake_strobe: got v=%b b=%b e=%b expected 0 1 0", cmd_valid, busy, frame_err);
        end
        send(8'h02);
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'b01, 4'h2}) begin
            failures++; $display("FAIL handshake_rd: got v=%b op=%h a=%h expected 1 1 2", cmd_valid, cmd_op, cmd_addr);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        logic e1;
        send(8'h55);
        e1 = frame_err;
        send(8'h66);
        checks++;
        if ({e1, frame_err, err_code, busy} !== {1'b1, 1'b1, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL back_to_back_err: got e1=%b e2=%b c=%h b=%b expected 1 1 1 0", e1, frame_err, err_code, busy);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        ready = 1'b0;
        send(8'hCC); send(8'h11);
        checks++;
        if ({busy, cmd_op, cmd_opa} !== {1'b1, 2'b10, 8'h11}) begin
            failures++; $display("FAIL midframe_pre: got b=%b op=%h a=%h expected 1 2 11", busy, cmd_op, cmd_opa);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, frame_err, err_code, busy} !== 42'd0) begin
            failures++;
            $display("FAIL midframe_async_reset: got %h expected 0",
                     {cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, frame_err, err_code, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        send(8'hDD); send(8'h03);
        checks++;
        if ({cmd_valid, cmd_op, cmd_fun, cmd_opa, frame_err} !== {1'b1, 2'b11, 4'h3, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_nop: got v=%b op=%h f=%h a=%h e=%b expected 1 3 3 0 0",
                     cmd_valid, cmd_op, cmd_fun, cmd_opa, frame_err);
        end
        accept();
    endtask

    initial begin
        test_reset();
        test_wr();
        test_alu_op();
        test_bad_opcode();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
